gmem_arbiter: RTL and testbench
===============================

# gmem_arbiter

Global data-memory arbiter sitting directly downstream of the GPU top-level memory ports. It accepts the per-channel read (load) and write (store) requests the GPU drives on its `mem2read_*` / `mem2write_*` ports. It serializes them round-robin onto one single-port synchronous SRAM and returns load data and store acknowledgements on the matching channel. There is at most one SRAM access in flight at a time.

## Interface
Parameters:
- `NUM_CHAN`, 4: number of GPU data channels (equals `THREADS_PER_CORE` at the top).
- `MEM_ADDR_WIDTH`, 8: address width.
- `MEM_DATA_WIDTH`, 16: data width.

Ports. Clocking is fixed: one clock; reset is asynchronous and active-low. Per-channel ports are unpacked arrays `[NUM_CHAN-1:0]`.
- `clk`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-low reset.
- `mem2read_req_addr_val`  in  1 each  load request valid.
- `mem2read_req_addr`  in  MEM_ADDR_WIDTH each  load address.
- `mem2read_req_rdy`  out  1 each  load request accepted when high with valid.
- `mem2read_resp_data_val`  out  1 each  load data valid.
- `mem2read_resp_data`  out  MEM_DATA_WIDTH each  load data.
- `mem2read_resp_rdy`  in  1 each  GPU ready to take load data.
- `mem2write_req_val`  in  1 each  store request valid.
- `mem2write_req_addr`  in  MEM_ADDR_WIDTH each  store address.
- `mem2write_req_data`  in  MEM_DATA_WIDTH each  store data.
- `mem2write_req_rdy`  out  1 each  store accepted when high with valid.
- `mem2write_resp_val`  out  1 each  one-cycle store-complete pulse.
- `sram_en`  out  1  SRAM access strobe.
- `sram_we`  out  1  SRAM write enable (meaningful only with `sram_en`).
- `sram_addr`  out  MEM_ADDR_WIDTH  SRAM address.
- `sram_wdata`  out  MEM_DATA_WIDTH  SRAM write data.
- `sram_rdata`  in  MEM_DATA_WIDTH  SRAM read data, valid the cycle after `sram_en && !sram_we`.

## Operation
- 2*NUM_CHAN request slots: slot 2i = channel i read, slot 2i+1 = channel i write.
- FSM states: IDLE, ACCESS, RD_WAIT, RD_RESP, WR_RESP.
- IDLE:
  - The round-robin picker selects the first requesting slot after `last_grant` (mod 2*NUM_CHAN).
  - The matching `*_req_rdy` is driven high combinationally; all other rdy are low.
  - On the handshake, latch channel, op, addr and data, update `last_grant`, and go to ACCESS.
  - With no request, stay in IDLE.
- ACCESS: drive `sram_en=1`, `sram_we=op`, `sram_addr`, `sram_wdata`. Go to RD_WAIT for a read, WR_RESP for a write.
- RD_WAIT: capture `sram_rdata` into the response register, then go to RD_RESP.
- RD_RESP:
  - Hold `mem2read_resp_data_val[ch]=1` with stable data until `mem2read_resp_rdy[ch]`.
  - On that handshake cycle go to IDLE. No new grants are made in this state.
- WR_RESP: pulse `mem2write_resp_val[ch]` for exactly one cycle, then go to IDLE.
- Read and write requests on the same channel in the same cycle are separate slots and are ordered by round-robin, never merged.
- The address is used unmodified; wrap-around is the SRAM's concern.
- Reset assertion at any time aborts the in-flight transaction. No response is produced and the SRAM is not accessed.

## Timing
- Reset values:
  - All `*_rdy`, `*_val`, `sram_en`, `sram_we` = 0.
  - `sram_addr`, `sram_wdata`, `mem2read_resp_data` = 0.
  - State = IDLE; `last_grant = 2*NUM_CHAN-1`, so slot 0 wins first.
- Outputs other than `*_req_rdy` are registered.
- Read: accept at cycle T, `sram_en` at T+1, `resp_val` from T+3 (zero-stall best case).
- Write: accept at T, SRAM write at T+1, `resp_val` pulse at T+2.
- The next grant is possible at T+4 for a read (if `resp_rdy` is already high at T+3) or at T+3 for a write.
- A valid held across cycles is not consumed until its own rdy is seen. Dropping valid before rdy is legal and discards the request.

## Structure
- `gmem_pkg` holds:
  - the state enum (IDLE/ACCESS/RD_WAIT/RD_RESP/WR_RESP);
  - the op encoding (OP_RD=0, OP_WR=1);
  - the slot-to-channel/op helper functions.
- Sub-module `rr_picker`: N-wide request vector plus `last_grant` in, one-hot grant and grant index out. Purely combinational, parameterized on N.

## Test plan
- Post-reset, ch0 read addr 0x10 with SRAM[0x10]=0xBEEF and `resp_rdy` tied high → `mem2read_resp_data[0]=0xBEEF`, val asserted 3 cycles after accept, for exactly 1 cycle.
- ch2 write addr 0x20 data 0x1234 → `sram_en=1`, `sram_we=1`, addr 0x20, wdata 0x1234 one cycle after accept; `mem2write_resp_val[2]` single pulse at T+2.
- All 8 slots requesting continuously → grants in order slots 0,1,…,7,0; no slot granted twice before all others are served.
- ch1 read with `mem2read_resp_rdy[1]` low for 5 cycles → val and data 0xA5A5 held stable; no `sram_en` and no other rdy during the stall; IDLE one cycle after rdy rises.
- ch3 simultaneous read 0x05 and write 0x05/0x7777 with `last_grant`=5 → read (slot 6) first and returns the old value, then the write; a later read returns 0x7777.
- Reset asserted in RD_WAIT → all outputs 0 asynchronously; no `resp_val` for the aborted read; after release the first grant goes to slot 0.

Source files
------------

// File: rtl/gmem_pkg.sv
// Shared types and slot helpers for the global data-memory arbiter.
// Slot 2i is channel i's load request and slot 2i+1 is its store request.
package gmem_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ACCESS  = 3'd1,
        RD_WAIT = 3'd2,
        RD_RESP = 3'd3,
        WR_RESP = 3'd4
    } state_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

    function automatic int unsigned slot_chan(input int unsigned slot);
        return slot >> 1;
    endfunction

    function automatic op_e slot_op(input int unsigned slot);
        return slot[0] ? OP_WR : OP_RD;
    endfunction

endpackage

// File: rtl/gmem_arbiter_rr_picker.sv
// Combinational round-robin picker: grants the first requester after last_grant.
module rr_picker #(
    parameter  int unsigned N  = 8,
    localparam int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic [N-1:0]  gnt_c,
    output logic [IW-1:0] gnt_idx_c
);

    int unsigned idx;
    logic        found;

    // Scan N slots starting one past last_grant, wrapping modulo N.
    always_comb begin
        gnt_c     = '0;
        gnt_idx_c = '0;
        found     = 1'b0;
        idx       = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = (32'(last_grant) + k) % N;
            if (!found && req[IW'(idx)]) begin
                found             = 1'b1;
                gnt_c[IW'(idx)]   = 1'b1;
                gnt_idx_c         = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/gmem_arbiter.sv
// Serializes per-channel load/store requests round-robin onto one single-port
// synchronous SRAM, one access in flight, returning data/acks per channel.
module gmem_arbiter
    import gmem_pkg::*;
#(
    parameter int unsigned NUM_CHAN       = 4,
    parameter int unsigned MEM_ADDR_WIDTH = 8,
    parameter int unsigned MEM_DATA_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      mem2read_req_addr_val  [NUM_CHAN-1:0],
    input  logic [MEM_ADDR_WIDTH-1:0] mem2read_req_addr      [NUM_CHAN-1:0],
    output logic                      mem2read_req_rdy       [NUM_CHAN-1:0],
    output logic                      mem2read_resp_data_val [NUM_CHAN-1:0],
    output logic [MEM_DATA_WIDTH-1:0] mem2read_resp_data     [NUM_CHAN-1:0],
    input  logic                      mem2read_resp_rdy      [NUM_CHAN-1:0],
    input  logic                      mem2write_req_val      [NUM_CHAN-1:0],
    input  logic [MEM_ADDR_WIDTH-1:0] mem2write_req_addr     [NUM_CHAN-1:0],
    input  logic [MEM_DATA_WIDTH-1:0] mem2write_req_data     [NUM_CHAN-1:0],
    output logic                      mem2write_req_rdy      [NUM_CHAN-1:0],
    output logic                      mem2write_resp_val     [NUM_CHAN-1:0],
    output logic                      sram_en,
    output logic                      sram_we,
    output logic [MEM_ADDR_WIDTH-1:0] sram_addr,
    output logic [MEM_DATA_WIDTH-1:0] sram_wdata,
    input  logic [MEM_DATA_WIDTH-1:0] sram_rdata
);

    localparam int unsigned NUM_SLOT = 2 * NUM_CHAN;
    localparam int unsigned SW       = $clog2(NUM_SLOT);
    localparam int unsigned CW       = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;

    state_e                    state_q, state_d;
    op_e                       op_q, op_d;
    logic [CW-1:0]             ch_q, ch_d;
    logic [SW-1:0]             last_grant_q, last_grant_d;
    logic                      sram_en_q, sram_en_d;
    logic                      sram_we_q, sram_we_d;
    logic [MEM_ADDR_WIDTH-1:0] sram_addr_q, sram_addr_d;
    logic [MEM_DATA_WIDTH-1:0] sram_wdata_q, sram_wdata_d;
    logic [MEM_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [NUM_CHAN-1:0]       rd_val_q, rd_val_d;
    logic [NUM_CHAN-1:0]       wr_val_q, wr_val_d;

    logic [NUM_SLOT-1:0]       req_c;
    logic [NUM_SLOT-1:0]       gnt_c;
    logic [SW-1:0]             gnt_idx_c;
    logic                      grant_c;

    rr_picker #(.N(NUM_SLOT)) u_picker (
        .req        (req_c),
        .last_grant (last_grant_q),
        .gnt_c      (gnt_c),
        .gnt_idx_c  (gnt_idx_c)
    );

    // Ready is only offered from IDLE and is forced low while reset is held.
    assign grant_c = reset && (state_q == IDLE) && (|gnt_c);

    for (genvar i = 0; i < NUM_CHAN; i++) begin : g_chan
        assign req_c[2*i]                = mem2read_req_addr_val[i];
        assign req_c[2*i+1]              = mem2write_req_val[i];
        assign mem2read_req_rdy[i]       = grant_c && gnt_c[2*i];
        assign mem2write_req_rdy[i]      = grant_c && gnt_c[2*i+1];
        assign mem2read_resp_data_val[i] = rd_val_q[i];
        assign mem2read_resp_data[i]     = rdata_q;
        assign mem2write_resp_val[i]     = wr_val_q[i];
    end

    assign sram_en    = sram_en_q;
    assign sram_we    = sram_we_q;
    assign sram_addr  = sram_addr_q;
    assign sram_wdata = sram_wdata_q;

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        ch_d         = ch_q;
        last_grant_d = last_grant_q;
        sram_en_d    = 1'b0;
        sram_we_d    = 1'b0;
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;
        rdata_d      = rdata_q;
        rd_val_d     = rd_val_q;
        wr_val_d     = '0;
        unique case (state_q)
            IDLE: begin
                if (grant_c) begin
                    op_d         = slot_op(32'(gnt_idx_c));
                    ch_d         = CW'(slot_chan(32'(gnt_idx_c)));
                    last_grant_d = gnt_idx_c;
                    sram_en_d    = 1'b1;
                    state_d      = ACCESS;
                    if (op_d == OP_WR) begin
                        sram_we_d    = 1'b1;
                        sram_addr_d  = mem2write_req_addr[ch_d];
                        sram_wdata_d = mem2write_req_data[ch_d];
                    end else begin
                        sram_addr_d  = mem2read_req_addr[ch_d];
                    end
                end
            end
            ACCESS: begin
                if (op_q == OP_WR) begin
                    wr_val_d[ch_q] = 1'b1;
                    state_d        = WR_RESP;
                end else begin
                    state_d        = RD_WAIT;
                end
            end
            RD_WAIT: begin
                rdata_d        = sram_rdata;
                rd_val_d[ch_q] = 1'b1;
                state_d        = RD_RESP;
            end
            RD_RESP: begin
                if (mem2read_resp_rdy[ch_q]) begin
                    rd_val_d[ch_q] = 1'b0;
                    state_d        = IDLE;
                end
            end
            WR_RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            op_q         <= OP_RD;
            ch_q         <= '0;
            last_grant_q <= SW'(NUM_SLOT - 1);
            sram_en_q    <= 1'b0;
            sram_we_q    <= 1'b0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            rdata_q      <= '0;
            rd_val_q     <= '0;
            wr_val_q     <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            ch_q         <= ch_d;
            last_grant_q <= last_grant_d;
            sram_en_q    <= sram_en_d;
            sram_we_q    <= sram_we_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
            rdata_q      <= rdata_d;
            rd_val_q     <= rd_val_d;
            wr_val_q     <= wr_val_d;
        end
    end

endmodule

// File: tb/tb_gmem_arbiter.sv
// Bench for gmem_arbiter: transaction-timing model checked every cycle plus
// directed scenarios with hand-computed expectations.
module tb_gmem_arbiter;

    localparam int NC = 4;
    localparam int NS = 2 * NC;
    localparam int AW = 8;
    localparam int DW = 16;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    logic          rd_val   [NC-1:0];
    logic [AW-1:0] rd_addr  [NC-1:0];
    logic          rd_rdy   [NC-1:0];
    logic          rsp_val  [NC-1:0];
    logic [DW-1:0] rsp_data [NC-1:0];
    logic          rsp_rdy  [NC-1:0];
    logic          wr_val   [NC-1:0];
    logic [AW-1:0] wr_addr  [NC-1:0];
    logic [DW-1:0] wr_data  [NC-1:0];
    logic          wr_rdy   [NC-1:0];
    logic          wr_rsp   [NC-1:0];
    logic          sram_en, sram_we;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata = '0;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit keep   = 1'b0;

    gmem_arbiter #(.NUM_CHAN(NC), .MEM_ADDR_WIDTH(AW), .MEM_DATA_WIDTH(DW)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .mem2read_req_addr_val  (rd_val),
        .mem2read_req_addr      (rd_addr),
        .mem2read_req_rdy       (rd_rdy),
        .mem2read_resp_data_val (rsp_val),
        .mem2read_resp_data     (rsp_data),
        .mem2read_resp_rdy      (rsp_rdy),
        .mem2write_req_val      (wr_val),
        .mem2write_req_addr     (wr_addr),
        .mem2write_req_data     (wr_data),
        .mem2write_req_rdy      (wr_rdy),
        .mem2write_resp_val     (wr_rsp),
        .sram_en                (sram_en),
        .sram_we                (sram_we),
        .sram_addr              (sram_addr),
        .sram_wdata             (sram_wdata),
        .sram_rdata             (sram_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        case (a)
            8'h10:   return 16'hBEEF;
            8'h30:   return 16'hA5A5;
            8'h05:   return 16'h1111;
            default: return DW'(a);
        endcase
    endfunction

    // Synchronous single-port SRAM stub
    logic [DW-1:0] sram    [256];
    bit            sram_wr [256];
    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_we) begin
                sram[sram_addr]    <= sram_wdata;
                sram_wr[sram_addr] <= 1'b1;
            end else begin
                sram_rdata <= sram_wr[sram_addr] ? sram[sram_addr] : init_val(sram_addr);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model state: slot picked by round-robin, cycles elapsed since acceptance.
    bit            m_busy  = 1'b0;
    int            m_phase = 0;
    int            m_last  = NS - 1;
    int            m_ch    = 0;
    bit            m_wr    = 1'b0;
    logic [AW-1:0] m_addr  = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [DW-1:0] m_rdata = '0;
    logic [DW-1:0] mmem    [256];
    bit            mm_wr   [256];

    bit            hs_rd   [NC];
    bit            hs_wr   [NC];
    int            rv_cnt  [NC];
    int            obs     [$];
    logic [DW-1:0] rdq     [$];

    always @(negedge clk) begin
        logic [NC-1:0] a_rr, a_wr, a_rv, a_wv, e_rr, e_wr, e_rv, e_wv;
        logic          e_en;
        int            pick;
        for (int i = 0; i < NC; i++) begin
            a_rr[i]   = rd_rdy[i];
            a_wr[i]   = wr_rdy[i];
            a_rv[i]   = rsp_val[i];
            a_wv[i]   = wr_rsp[i];
            hs_rd[i]  = rd_val[i] && rd_rdy[i];
            hs_wr[i]  = wr_val[i] && wr_rdy[i];
            if (hs_rd[i]) obs.push_back(2 * i);
            if (hs_wr[i]) obs.push_back(2 * i + 1);
            if (rsp_val[i]) rv_cnt[i]++;
            if (rsp_val[i] && rsp_rdy[i]) rdq.push_back(rsp_data[i]);
        end
        if (!reset) begin
            chk("reset_sram", 32'({sram_en, sram_we, sram_addr, sram_wdata}), 32'd0);
            chk("reset_hs", 32'({a_rr, a_wr, a_rv, a_wv}), 32'd0);
            chk("reset_data", 32'(rsp_data[0]), 32'd0);
            m_busy = 1'b0;
            m_last = NS - 1;
        end else begin
            e_rr = '0; e_wr = '0; e_rv = '0; e_wv = '0; e_en = 1'b0;
            pick = -1;
            if (!m_busy) begin
                for (int k = 1; k <= NS; k++) begin
                    int s;
                    s = (m_last + k) % NS;
                    if (pick < 0 && ((s % 2 == 1) ? wr_val[s / 2] : rd_val[s / 2])) pick = s;
                end
                if (pick >= 0) begin
                    if (pick % 2 == 1) e_wr[pick / 2] = 1'b1;
                    else               e_rr[pick / 2] = 1'b1;
                end
            end else if (m_phase == 1) begin
                e_en = 1'b1;
            end else if (m_wr && m_phase == 2) begin
                e_wv[m_ch] = 1'b1;
            end else if (!m_wr && m_phase >= 3) begin
                e_rv[m_ch] = 1'b1;
            end
            chk("rd_req_rdy", 32'(a_rr), 32'(e_rr));
            chk("wr_req_rdy", 32'(a_wr), 32'(e_wr));
            chk("rd_resp_val", 32'(a_rv), 32'(e_rv));
            chk("wr_resp_val", 32'(a_wv), 32'(e_wv));
            chk("sram_en", 32'(sram_en), 32'(e_en));
            if (e_en) begin
                chk("sram_we", 32'(sram_we), 32'(m_wr));
                chk("sram_addr", 32'(sram_addr), 32'(m_addr));
                if (m_wr) chk("sram_wdata", 32'(sram_wdata), 32'(m_wdata));
            end
            if (m_busy && !m_wr && m_phase >= 3) chk("rd_data", 32'(rsp_data[m_ch]), 32'(m_rdata));
            // Advance the model to the next cycle.
            if (!m_busy) begin
                if (pick >= 0) begin
                    m_busy  = 1'b1;
                    m_phase = 1;
                    m_last  = pick;
                    m_ch    = pick / 2;
                    m_wr    = (pick % 2) == 1;
                    m_addr  = m_wr ? wr_addr[m_ch] : rd_addr[m_ch];
                    m_wdata = wr_data[m_ch];
                end
            end else if (m_wr) begin
                if (m_phase == 1) begin
                    mmem[m_addr]  = m_wdata;
                    mm_wr[m_addr] = 1'b1;
                end
                if (m_phase == 2) m_busy = 1'b0;
                else              m_phase++;
            end else begin
                if (m_phase == 1) m_rdata = mm_wr[m_addr] ? mmem[m_addr] : init_val(m_addr);
                if (m_phase >= 3 && rsp_rdy[m_ch]) m_busy = 1'b0;
                else                               m_phase++;
            end
        end
    end

    // Advance one cycle; requests are withdrawn once their handshake was seen.
    task automatic step();
        @(posedge clk);
        #1;
        if (!keep) begin
            for (int i = 0; i < NC; i++) begin
                if (hs_rd[i]) rd_val[i] = 1'b0;
                if (hs_wr[i]) wr_val[i] = 1'b0;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int base_o, base_r, snap;
        for (int i = 0; i < NC; i++) begin
            rd_val[i] = 1'b0; rd_addr[i] = '0; rsp_rdy[i] = 1'b1;
            wr_val[i] = 1'b0; wr_addr[i] = '0; wr_data[i] = '0;
        end

        // Reset with a pending request: nothing may be offered ready.
        rd_val[0] = 1'b1; rd_addr[0] = 8'h10;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rd_rdy0", 32'(rd_rdy[0]), 32'd0);
        chk("rst_sram_en", 32'(sram_en), 32'd0);

        // ch0 read 0x10 -> 0xBEEF, response 3 cycles after accept for 1 cycle
        step(); reset = 1'b1;
        @(negedge clk); chk("t1_accept", 32'(rd_rdy[0]), 32'd1);
        step(); @(negedge clk);
        chk("t1_sram_en", 32'(sram_en), 32'd1);
        chk("t1_sram_addr", 32'(sram_addr), 32'h10);
        chk("t1_sram_we", 32'(sram_we), 32'd0);
        step(); @(negedge clk); chk("t1_val_t2", 32'(rsp_val[0]), 32'd0);
        step(); @(negedge clk);
        chk("t1_val_t3", 32'(rsp_val[0]), 32'd1);
        chk("t1_data", 32'(rsp_data[0]), 32'hBEEF);
        step(); @(negedge clk); chk("t1_val_t4", 32'(rsp_val[0]), 32'd0);

        // ch2 write 0x20/0x1234
        step(); wr_val[2] = 1'b1; wr_addr[2] = 8'h20; wr_data[2] = 16'h1234;
        @(negedge clk); chk("t2_accept", 32'(wr_rdy[2]), 32'd1);
        step(); @(negedge clk);
        chk("t2_sram", 32'({sram_en, sram_we, sram_addr, sram_wdata}), 32'({1'b1, 1'b1, 8'h20, 16'h1234}));
        step(); @(negedge clk); chk("t2_resp_t2", 32'(wr_rsp[2]), 32'd1);
        step(); @(negedge clk); chk("t2_resp_t3", 32'(wr_rsp[2]), 32'd0);

        // All 8 slots requesting continuously after a fresh reset
        step(); reset = 1'b0;
        for (int i = 0; i < NC; i++) begin
            rd_val[i] = 1'b1; rd_addr[i] = AW'(8'h50 + i);
            wr_val[i] = 1'b1; wr_addr[i] = AW'(8'h60 + i); wr_data[i] = DW'(16'h0100 + i);
        end
        keep = 1'b1;
        step(); step(); reset = 1'b1;
        base_o = obs.size();
        for (int n = 0; n < 200 && obs.size() < base_o + 9; n++) step();
        for (int i = 0; i < NC; i++) begin rd_val[i] = 1'b0; wr_val[i] = 1'b0; end
        keep = 1'b0;
        for (int j = 0; j < 9; j++)
            chk("t3_order", (obs.size() > base_o + j) ? 32'(obs[base_o + j]) : 32'hFFFF_FFFF, 32'(j % 8));
        repeat (6) step();

        // ch1 read 0x30 stalled by resp_rdy low for 5 cycles, ch0 waiting
        rsp_rdy[1] = 1'b0; rd_val[1] = 1'b1; rd_addr[1] = 8'h30;
        @(negedge clk); chk("t4_accept", 32'(rd_rdy[1]), 32'd1);
        step(); rd_val[0] = 1'b1; rd_addr[0] = 8'h10;
        step(); step();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("t4_stall_val", 32'(rsp_val[1]), 32'd1);
            chk("t4_stall_data", 32'(rsp_data[1]), 32'hA5A5);
            chk("t4_stall_rdy0", 32'(rd_rdy[0]), 32'd0);
            chk("t4_stall_en", 32'(sram_en), 32'd0);
            step();
        end
        rsp_rdy[1] = 1'b1;
        @(negedge clk); chk("t4_hs_val", 32'(rsp_val[1]), 32'd1);
        step(); @(negedge clk);
        chk("t4_idle_rdy0", 32'(rd_rdy[0]), 32'd1);
        chk("t4_val_drop", 32'(rsp_val[1]), 32'd0);
        repeat (6) step();

        // last_grant=5, then ch3 read and write to 0x05 together
        wr_val[2] = 1'b1; wr_addr[2] = 8'h40; wr_data[2] = 16'h4444;
        repeat (5) step();
        base_o = obs.size();
        base_r = rdq.size();
        rd_val[3] = 1'b1; rd_addr[3] = 8'h05;
        wr_val[3] = 1'b1; wr_addr[3] = 8'h05; wr_data[3] = 16'h7777;
        repeat (10) step();
        rd_val[3] = 1'b1; rd_addr[3] = 8'h05;
        repeat (6) step();
        chk("t5_first",  (obs.size() > base_o)     ? 32'(obs[base_o])     : 32'hFFFF_FFFF, 32'd6);
        chk("t5_second", (obs.size() > base_o + 1) ? 32'(obs[base_o + 1]) : 32'hFFFF_FFFF, 32'd7);
        chk("t5_third",  (obs.size() > base_o + 2) ? 32'(obs[base_o + 2]) : 32'hFFFF_FFFF, 32'd6);
        chk("t5_old_data", (rdq.size() > base_r)     ? 32'(rdq[base_r])     : 32'hFFFF_FFFF, 32'h1111);
        chk("t5_new_data", (rdq.size() > base_r + 1) ? 32'(rdq[base_r + 1]) : 32'hFFFF_FFFF, 32'h7777);

        // Reset during RD_WAIT aborts the ch2 read
        step(); rd_val[2] = 1'b1; rd_addr[2] = 8'h10;
        @(negedge clk); chk("t6_accept", 32'(rd_rdy[2]), 32'd1);
        snap = rv_cnt[2];
        step(); step();
        reset = 1'b0;
        rd_val[0] = 1'b1; rd_addr[0] = 8'h22;
        wr_val[1] = 1'b1; wr_addr[1] = 8'h23; wr_data[1] = 16'h5555;
        #1;
        chk("t6_async_addr", 32'(sram_addr), 32'd0);
        chk("t6_async_en", 32'(sram_en), 32'd0);
        chk("t6_async_rdy0", 32'(rd_rdy[0]), 32'd0);
        step(); step(); reset = 1'b1;
        @(negedge clk);
        chk("t6_first_slot0", 32'(rd_rdy[0]), 32'd1);
        chk("t6_first_not3", 32'(wr_rdy[1]), 32'd0);
        repeat (12) step();
        chk("t6_no_resp_ch2", 32'(rv_cnt[2]), 32'(snap));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
